// File: rtl/fabric_lockstep_checker_if.sv
// Bus bundle for fabric_lockstep_checker.
//   master : engine side (drives memory address, config port, user reset, status)
//   slave  : harness side (drives start/skip_load/cmp_mask, memory data,
//            fabric and gold vectors)
interface fabric_lockstep_checker_if #(
    parameter int WIDTH  = 28,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic                 start;
    logic                 skip_load;
    logic [WIDTH-1:0]     cmp_mask;
    logic [ADDR_W-1:0]    mem_addr;
    logic [31:0]          mem_data;
    logic [31:0]          SelfWriteData;
    logic                 SelfWriteStrobe;
    logic [WIDTH-1:0]     user_reset;
    logic [WIDTH-1:0]     fab_I;
    logic [WIDTH-1:0]     fab_T;
    logic [WIDTH-1:0]     gold_I;
    logic [WIDTH-1:0]     gold_T;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     err_count;
    logic [CNT_W-1:0]     first_err_cycle;
    logic [2*WIDTH-1:0]   first_err_bits;

    modport master (
        input  start, skip_load, cmp_mask, mem_data, fab_I, fab_T, gold_I, gold_T,
        output mem_addr, SelfWriteData, SelfWriteStrobe, user_reset,
               busy, done, pass, err_count, first_err_cycle, first_err_bits
    );

    modport slave (
        output start, skip_load, cmp_mask, mem_data, fab_I, fab_T, gold_I, gold_T,
        input  mem_addr, SelfWriteData, SelfWriteStrobe, user_reset,
               busy, done, pass, err_count, first_err_cycle, first_err_bits
    );
endinterface

// File: rtl/fabric_lockstep_checker.sv
// Bring-up engine for eFPGA_top: streams a bitstream from word memory into
// the SelfWriteData/SelfWriteStrobe port, pulses the user reset, then
// compares fabric I/T outputs against a gold model for CHECK_CYCLES cycles.
// Ports:
//   CLK    : clock
//   reset  : synchronous active-high reset (aborts any run)
//   bus    : fabric_lockstep_checker_if.master (control, memory, config
//            port, fabric/gold vectors, status and first-mismatch capture)
module fabric_lockstep_checker #(
    parameter int WIDTH         = 28,
    parameter int ADDR_W        = 12,
    parameter int SETUP_CYCLES  = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int URST_CYCLES   = 5,
    parameter int CHECK_CYCLES  = 100,
    parameter int CNT_W         = 16
) (
    input  logic                        CLK,
    input  logic                        reset,
    fabric_lockstep_checker_if.master   bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_SETUP  = 4'd2;
    localparam logic [3:0] S_STROBE = 4'd3;
    localparam logic [3:0] S_GAP    = 4'd4;
    localparam logic [3:0] S_SETTLE = 4'd5;
    localparam logic [3:0] S_URST   = 4'd6;
    localparam logic [3:0] S_CHECK  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]         state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   fcyc_q, fcyc_d;
    logic [2*WIDTH-1:0] fbits_q, fbits_d;
    logic               pass_q, pass_d;

    logic [WIDTH-1:0]   diff_i, diff_t;
    logic               mismatch;

    always_comb begin
        diff_i   = (bus.fab_I ^ bus.gold_I) & bus.cmp_mask;
        diff_t   = (bus.fab_T ^ bus.gold_T) & bus.cmp_mask;
        mismatch = |{diff_i, diff_t};

        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        fcyc_d  = fcyc_q;
        fbits_d = fbits_q;
        pass_d  = pass_q;

        // Timed states count down to 0; CHECK counts up so the counter
        // doubles as the compare-cycle index.
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    err_d   = '0;
                    fcyc_d  = '0;
                    fbits_d = '0;
                    pass_d  = 1'b0;
                    addr_d  = '0;
                    if (bus.skip_load) begin
                        state_d = S_SETTLE;
                        cnt_d   = 32'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wdata_d = bus.mem_data;
                state_d = S_SETUP;
                cnt_d   = 32'(SETUP_CYCLES - 1);
            end
            S_SETUP: begin
                if (cnt_q == '0) state_d = S_STROBE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            S_STROBE: begin
                state_d = S_GAP;
                cnt_d   = 32'(GAP_CYCLES - 1);
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (&addr_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = 32'(SETTLE_CYCLES - 1);
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_URST;
                    cnt_d   = 32'(URST_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_URST: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    // err_count saturates, so zero reliably means "no mismatch yet".
                    if (err_q == '0) begin
                        fcyc_d  = cnt_q[CNT_W-1:0];
                        fbits_d = {diff_i, diff_t};
                    end
                    if (err_q != '1) err_d = err_q + 1'b1;
                end
                if (cnt_q == 32'(CHECK_CYCLES - 1)) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
            fcyc_q  <= '0;
            fbits_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            fcyc_q  <= fcyc_d;
            fbits_q <= fbits_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.mem_addr        = addr_q;
    assign bus.SelfWriteData   = wdata_q;
    assign bus.SelfWriteStrobe = (state_q == S_STROBE);
    assign bus.user_reset      = {{(WIDTH-1){1'b0}}, (state_q == S_URST)};
    assign bus.busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_cycle = fcyc_q;
    assign bus.first_err_bits  = fbits_q;

endmodule

// File: tb/tb_fabric_lockstep_checker.sv
// Directed self-checking bench for fabric_lockstep_checker (ADDR_W = 2).
module tb_fabric_lockstep_checker;
    localparam int WIDTH  = 28;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;
    localparam logic [WIDTH-1:0] PAT = 28'h0ABCDEF;
    localparam logic [WIDTH-1:0] GT  = 28'h5A5A5A5;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    fabric_lockstep_checker_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fabric_lockstep_checker #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETUP_CYCLES(2), .GAP_CYCLES(2),
        .SETTLE_CYCLES(100), .URST_CYCLES(5), .CHECK_CYCLES(100), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] mem [4];
    always @(negedge CLK) bus.mem_data <= mem[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from run_observe
    int strobe_n, urst_n, urst_first, urst_other, done_cyc, busy_drop;
    int strobe_at [8];
    logic [31:0] sd [8][3];
    logic [CNT_W-1:0] err0, fcyc0;
    logic busy0, done0;

    // Pulses start, then samples one cycle per iteration (c = 0 is the
    // first cycle after start is taken) until done or the cycle budget ends.
    task automatic run_observe(input bit skip, input bit flip, input int start_again_at);
        int base;
        logic [31:0] h1, h2;
        base = skip ? 105 : 129;
        strobe_n = 0; urst_n = 0; urst_first = -1; urst_other = 0;
        done_cyc = -1; busy_drop = 0; h1 = '0; h2 = '0;
        bus.skip_load = skip;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c == 0) begin
                err0 = bus.err_count; fcyc0 = bus.first_err_cycle;
                busy0 = bus.busy; done0 = bus.done;
            end
            if (bus.SelfWriteStrobe) begin
                if (strobe_n < 8) begin
                    strobe_at[strobe_n] = c;
                    sd[strobe_n][0] = h2;
                    sd[strobe_n][1] = h1;
                    sd[strobe_n][2] = bus.SelfWriteData;
                end
                strobe_n++;
            end
            if (bus.user_reset[0]) begin
                if (urst_n == 0) urst_first = c;
                urst_n++;
            end
            if (bus.user_reset[WIDTH-1:1] != '0) urst_other++;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (!bus.busy) busy_drop++;
            h2 = h1;
            h1 = bus.SelfWriteData;
            bus.fab_I = (flip && ((c - base) == 7 || (c - base) == 20)) ? (PAT ^ 28'h8) : PAT;
            bus.start = (c == start_again_at);
            @(posedge CLK); #1;
        end
        bus.fab_I = PAT;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
        n_cmp++; if (bus.SelfWriteData !== '0) begin n_bad++; $display("FAIL reset_wdata got %h exp 0", bus.SelfWriteData); end
        n_cmp++; if (bus.SelfWriteStrobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b exp 0", bus.SelfWriteStrobe); end
        n_cmp++; if (bus.user_reset !== '0) begin n_bad++; $display("FAIL reset_user_reset got %h exp 0", bus.user_reset); end
        n_cmp++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b exp 000", {bus.busy, bus.done, bus.pass}); end
        n_cmp++; if ({bus.err_count, bus.first_err_cycle, bus.first_err_bits} !== '0) begin n_bad++; $display("FAIL reset_err got %h exp 0", {bus.err_count, bus.first_err_cycle, bus.first_err_bits}); end
        reset = 1'b0;
        @(posedge CLK); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_load_and_pass;
        run_observe(1'b0, 1'b0, -1);
        n_cmp++; if (strobe_n !== 4) begin n_bad++; $display("FAIL load_strobe_count got %0d exp 4", strobe_n); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (strobe_at[i] !== 3 + 6 * i) begin n_bad++; $display("FAIL load_strobe_time[%0d] got %0d exp %0d", i, strobe_at[i], 3 + 6 * i); end
            for (int j = 0; j < 3; j++) begin
                n_cmp++; if (sd[i][j] !== mem[i]) begin n_bad++; $display("FAIL load_wdata[%0d][%0d] got %h exp %h", i, j, sd[i][j], mem[i]); end
            end
        end
        n_cmp++; if (busy_drop !== 0) begin n_bad++; $display("FAIL load_busy_drop got %0d exp 0", busy_drop); end
        n_cmp++; if (urst_first !== 124) begin n_bad++; $display("FAIL load_urst_start got %0d exp 124", urst_first); end
        n_cmp++; if (urst_n !== 5) begin n_bad++; $display("FAIL load_urst_len got %0d exp 5", urst_n); end
        n_cmp++; if (urst_other !== 0) begin n_bad++; $display("FAIL load_urst_upper got %0d exp 0", urst_other); end
        n_cmp++; if (done_cyc !== 229) begin n_bad++; $display("FAIL load_done_cycle got %0d exp 229", done_cyc); end
        n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL load_pass got %b exp 1", bus.pass); end
        n_cmp++; if (bus.err_count !== '0) begin n_bad++; $display("FAIL load_err got %0d exp 0", bus.err_count); end
    endtask

    task automatic test_mismatch;
        run_observe(1'b1, 1'b1, -1);
        n_cmp++; if (strobe_n !== 0) begin n_bad++; $display("FAIL mm_strobes got %0d exp 0", strobe_n); end
        n_cmp++; if (urst_first !== 100) begin n_bad++; $display("FAIL mm_urst_start got %0d exp 100", urst_first); end
        n_cmp++; if (done_cyc !== 205) begin n_bad++; $display("FAIL mm_done_cycle got %0d exp 205", done_cyc); end
        n_cmp++; if (bus.err_count !== 16'd2) begin n_bad++; $display("FAIL mm_err got %0d exp 2", bus.err_count); end
        n_cmp++; if (bus.first_err_cycle !== 16'd7) begin n_bad++; $display("FAIL mm_first_cycle got %0d exp 7", bus.first_err_cycle); end
        n_cmp++; if (bus.first_err_bits !== {28'h8, 28'h0}) begin n_bad++; $display("FAIL mm_first_bits got %h exp %h", bus.first_err_bits, {28'h8, 28'h0}); end
        n_cmp++; if (bus.pass !== 1'b0) begin n_bad++; $display("FAIL mm_pass got %b exp 0", bus.pass); end
    endtask

    task automatic test_mask;
        bus.cmp_mask = 28'hFFFFFF7;
        run_observe(1'b1, 1'b1, -1);
        n_cmp++; if (err0 !== '0) begin n_bad++; $display("FAIL mask_cleared_on_start got %0d exp 0", err0); end
        n_cmp++; if (bus.err_count !== '0) begin n_bad++; $display("FAIL mask_err got %0d exp 0", bus.err_count); end
        n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL mask_pass got %b exp 1", bus.pass); end
        bus.cmp_mask = '0;
        bus.gold_I = ~PAT;
        bus.gold_T = ~GT;
        run_observe(1'b1, 1'b0, -1);
        n_cmp++; if ({bus.pass, bus.err_count} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL mask_zero got %h exp 10000", {bus.pass, bus.err_count}); end
        bus.cmp_mask = '1;
        bus.gold_I = PAT;
        bus.gold_T = GT;
    endtask

    task automatic test_start_ignored;
        run_observe(1'b1, 1'b1, 150);
        n_cmp++; if (done_cyc !== 205) begin n_bad++; $display("FAIL busy_start_done_cycle got %0d exp 205", done_cyc); end
        n_cmp++; if (bus.err_count !== 16'd2) begin n_bad++; $display("FAIL busy_start_err got %0d exp 2", bus.err_count); end
        n_cmp++; if (bus.first_err_cycle !== 16'd7) begin n_bad++; $display("FAIL busy_start_first got %0d exp 7", bus.first_err_cycle); end
    endtask

    task automatic test_restart_from_done;
        run_observe(1'b1, 1'b0, -1);
        n_cmp++; if (err0 !== '0) begin n_bad++; $display("FAIL restart_err_clear got %0d exp 0", err0); end
        n_cmp++; if (fcyc0 !== '0) begin n_bad++; $display("FAIL restart_first_clear got %0d exp 0", fcyc0); end
        n_cmp++; if ({busy0, done0} !== 2'b10) begin n_bad++; $display("FAIL restart_status got %b exp 10", {busy0, done0}); end
        n_cmp++; if (done_cyc !== 205) begin n_bad++; $display("FAIL restart_done_cycle got %0d exp 205", done_cyc); end
        n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass got %b exp 1", bus.pass); end
    endtask

    task automatic test_reset_abort;
        int pre, post;
        pre = 0; post = 0;
        bus.skip_load = 1'b0;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (bus.SelfWriteStrobe) pre++;
            @(posedge CLK); #1;
        end
        n_cmp++; if (bus.SelfWriteData !== mem[2]) begin n_bad++; $display("FAIL abort_third_setup got %h exp %h", bus.SelfWriteData, mem[2]); end
        n_cmp++; if (pre !== 2) begin n_bad++; $display("FAIL abort_pre_strobes got %0d exp 2", pre); end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        n_cmp++; if ({bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe, bus.user_reset} !== '0) begin n_bad++; $display("FAIL abort_outputs got %h exp 0", {bus.mem_addr, bus.SelfWriteData, bus.SelfWriteStrobe, bus.user_reset}); end
        n_cmp++; if ({bus.busy, bus.done, bus.pass, bus.err_count} !== '0) begin n_bad++; $display("FAIL abort_status got %h exp 0", {bus.busy, bus.done, bus.pass, bus.err_count}); end
        for (int c = 0; c < 40; c++) begin
            if (bus.SelfWriteStrobe) post++;
            @(posedge CLK); #1;
        end
        n_cmp++; if (post !== 0) begin n_bad++; $display("FAIL abort_post_strobes got %0d exp 0", post); end
        run_observe(1'b1, 1'b0, -1);
        n_cmp++; if (strobe_n !== 0) begin n_bad++; $display("FAIL skip_strobes got %0d exp 0", strobe_n); end
        n_cmp++; if (urst_first !== 100) begin n_bad++; $display("FAIL skip_urst_start got %0d exp 100", urst_first); end
        n_cmp++; if (done_cyc !== 205) begin n_bad++; $display("FAIL skip_done_cycle got %0d exp 205", done_cyc); end
    endtask

    initial begin
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        mem[2] = 32'h99AABBCC;
        mem[3] = 32'hDDEEFF00;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.skip_load = 1'b0;
        bus.cmp_mask = '1;
        bus.fab_I = PAT;
        bus.gold_I = PAT;
        bus.fab_T = GT;
        bus.gold_T = GT;
        test_reset();
        test_load_and_pass();
        test_mismatch();
        test_mask();
        test_start_ignored();
        test_restart_from_done();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fabric_lockstep_checker.md
Name: fabric_lockstep_checker

Overview:
Self-contained, synthesizable bring-up engine for eFPGA_top.
- Streams a bitstream from a synchronous word memory into the SelfWriteData/SelfWriteStrobe configuration port with programmable timing.
- Pulses a user-design reset, then compares fabric I/T outputs against a gold model for a programmable number of cycles.
- Reports pass/fail, error count and first-mismatch capture.
- Sits beside eFPGA_top in on-chip or emulation harnesses, replacing bench-driven loading and checking.

Parameters:
WIDTH, 28, number of compared I/O bits per vector
ADDR_W, 12, word-memory address width; words loaded = 2**ADDR_W
SETUP_CYCLES, 2, cycles SelfWriteData is stable before strobe (>=1)
GAP_CYCLES, 2, cycles after strobe before next word (>=1)
SETTLE_CYCLES, 100, idle cycles between load end and user reset
URST_CYCLES, 5, user reset pulse length (>=1)
CHECK_CYCLES, 100, number of compare cycles (>=1)
CNT_W, 16, width of error counter and cycle stamp

Ports:
CLK  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle pulse starts a run; ignored unless state is IDLE or DONE
skip_load  in  1  sampled with start; 1 bypasses LOAD and goes straight to SETTLE
cmp_mask  in  WIDTH  1 = bit compared; applies to both I and T vectors
mem_addr  out  ADDR_W  word-memory address
mem_data  in  32  word at mem_addr, valid one cycle after mem_addr changes
SelfWriteData  out  32  configuration word
SelfWriteStrobe  out  1  configuration write strobe
user_reset  out  WIDTH  bit 0 = user reset pulse, other bits 0
fab_I  in  WIDTH  fabric I_top
fab_T  in  WIDTH  fabric T_top
gold_I  in  WIDTH  gold io_out
gold_T  in  WIDTH  gold output enable (already inverted oeb)
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
pass  out  1  valid when done: 1 iff err_count == 0
err_count  out  CNT_W  mismatching compare cycles, saturating at all-ones
first_err_cycle  out  CNT_W  compare-cycle index (0-based) of first mismatch
first_err_bits  out  2*WIDTH  {I xor-diff, T xor-diff} (masked) at first mismatch

Behaviour:
- Reset: state IDLE; all outputs 0, including mem_addr, SelfWriteData, SelfWriteStrobe, user_reset, err_count, first_err_*, pass and done. Reset mid-run aborts immediately; no further strobes issue.
- States: IDLE -> FETCH -> SETUP -> STROBE -> GAP -> (FETCH | SETTLE) -> URST -> CHECK -> DONE.
- IDLE/DONE + start: clear err_count, first_err_* and pass; mem_addr = 0. Go to FETCH, or to SETTLE if skip_load = 1.
- FETCH: 1 cycle, waiting on memory latency.
- SETUP: on entry, SelfWriteData latches mem_data and holds it until the next FETCH completes. Lasts SETUP_CYCLES cycles.
- STROBE: SelfWriteStrobe = 1 for exactly 1 cycle.
- GAP: lasts GAP_CYCLES cycles. On exit, if mem_addr == all-ones, go to SETTLE; otherwise increment mem_addr and go to FETCH. No wrap-around; the last word is strobed exactly once.
- Per-word period = 1 + SETUP_CYCLES + 1 + GAP_CYCLES (default 6 cycles).
- SETTLE: SETTLE_CYCLES cycles, with SelfWriteStrobe = 0.
- URST: user_reset[0] = 1 for URST_CYCLES cycles; it drops on entry to CHECK.
- CHECK: runs CHECK_CYCLES cycles, with index k = 0..CHECK_CYCLES-1.
  - Each cycle: dI = (fab_I ^ gold_I) & cmp_mask; dT = (fab_T ^ gold_T) & cmp_mask.
  - If dI | dT is nonzero, err_count increments (saturating).
  - On the first mismatch only, capture first_err_cycle = k and first_err_bits = {dI, dT}.
- DONE: done = 1; pass registered as (err_count == 0). Outputs hold until the next start or reset.
- start arriving in any busy state is ignored.
- cmp_mask = 0 always yields pass.

Test Plan:
- ADDR_W=2, words 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; start -> exactly 4 strobe pulses 6 cycles apart; SelfWriteData equals each word on the strobe cycle and for the 2 preceding cycles; then busy stays high through SETTLE.
- Gold = fabric = 0x0ABCDEF, CHECK_CYCLES=100 -> user_reset[0] high exactly 5 cycles, done after 100 compare cycles, pass=1, err_count=0.
- Force fab_I[3] flipped on compare cycles 7 and 20 only -> err_count=2, first_err_cycle=7, first_err_bits = {28'h8, 28'h0}, pass=0.
- Same mismatch with cmp_mask[3]=0 -> pass=1, err_count=0.
- Assert reset during the third word's SETUP -> next cycle all outputs 0 and no further strobes. Then start with skip_load=1 -> zero strobes, URST follows after 100 cycles.
- start pulsed again during CHECK -> ignored (err_count and timing unchanged). start in DONE -> counters clear and a new run begins.
